// File: rtl/iru_in_buffer_if.sv
// Bus bundle for the IRU input tile buffer.
// Signals:
//   in_valid/in_ready/in_data : upstream beat stream (valid/ready handshake)
//   full                      : a complete tile is held and reads return data
//   rel                       : consumer pulse that releases the held tile
//   rd/row/col                : 5-lane read strobes and row/col addresses
//   q                         : 5-lane registered read data
// Modports: master = upstream producer + rotation-lane consumer, slave = buffer.
interface iru_in_buffer_if #(
  parameter int BEAT_PIX = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [8*BEAT_PIX-1:0]   in_data;
  logic                    full;
  logic                    rel;
  logic [4:0]              rd;
  logic [4:0][4:0]         row;
  logic [4:0][4:0]         col;
  logic [4:0][7:0]         q;

  modport master (
    output in_valid, in_data, rel, rd, row, col,
    input  in_ready, full, q
  );

  modport slave (
    input  in_valid, in_data, rel, rd, row, col,
    output in_ready, full, q
  );
endinterface

// File: rtl/iru_in_buffer.sv
// Input-side tile buffer for the image rotation unit.
// Collects one DIM x DIM tile of bytes from a stream of BEAT_PIX-pixel beats,
// then holds it and serves five independent registered random reads until
// the consumer releases it.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   z     : synchronous clear of state, beat count, read data and storage
//   bus   : slave side of iru_in_buffer_if (stream in, release, 5 read lanes)
module iru_in_buffer #(
  parameter int DIM      = 20,
  parameter int BEAT_PIX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             z,
  iru_in_buffer_if.slave   bus
);
  localparam int NPIX   = DIM * DIM;
  localparam int NBEATS = NPIX / BEAT_PIX;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_mem [NPIX];
  logic            w_accept;
  logic            w_last;
  logic            w_full;
  logic [ADDR_W-1:0] w_wbase;

  // Status comes straight from the state register: no input-to-output path.
  assign w_full       = (r_state == FULL);
  assign bus.full     = w_full;
  assign bus.in_ready = (r_state == LOAD);

  assign w_accept = bus.in_valid && (r_state == LOAD);
  assign w_last   = (r_cnt == CW'(NBEATS - 1));
  // Linear pixel index of byte 0 of the current beat; beats may straddle rows.
  assign w_wbase  = ADDR_W'(int'(r_cnt) * BEAT_PIX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (z) begin
      w_state_next = LOAD;
    end else begin
      case (r_state)
        LOAD:    if (w_accept && w_last) w_state_next = FULL;
        FULL:    if (bus.rel)            w_state_next = LOAD;
        default: w_state_next = LOAD;
      endcase
    end
  end

  // Beat counter and tile storage. Storage is held row-major as a flat array,
  // so pixel p lands at row p/DIM, col p%DIM without any explicit divide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int p = 0; p < NPIX; p++) r_mem[p] <= '0;
    end else if (z) begin
      r_cnt <= '0;
      for (int p = 0; p < NPIX; p++) r_mem[p] <= '0;
    end else if (w_accept) begin
      for (int j = 0; j < BEAT_PIX; j++) begin
        r_mem[w_wbase + ADDR_W'(j)] <= bus.in_data[8*j +: 8];
      end
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  // Five independent read lanes; each holds its data until its next strobe.
  // Reads see the pre-edge state, so a read alongside rel still gets tile data.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_lane
      logic              w_in_range;
      logic [ADDR_W-1:0] w_addr;
      logic [7:0]        r_q;

      assign w_in_range = (int'(bus.row[gi]) < DIM) && (int'(bus.col[gi]) < DIM);
      assign w_addr     = ADDR_W'(int'(bus.row[gi]) * DIM + int'(bus.col[gi]));
      assign bus.q[gi]  = r_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (z) begin
          r_q <= '0;
        end else if (bus.rd[gi]) begin
          r_q <= (w_full && w_in_range) ? r_mem[w_addr] : 8'h00;
        end
      end
    end
  endgenerate
endmodule

// File: doc/iru_in_buffer.md
# iru_in_buffer

Input-side tile buffer for the image rotation unit. It accepts one 20x20 tile of 8-bit pixels as a stream of 64-bit beats under a valid/ready handshake. It then holds the tile and serves independent registered random reads to the 5 rotation lanes until the consumer releases it. It is the feeder counterpart of the IRU output buffer, and its read ports use the same 5-lane row/col addressing.

## Interface
Parameters:
- DIM, 20, tile edge length in pixels; the tile is DIM x DIM, stored row-major.
- BEAT_PIX, 8, pixels per input beat; DIM*DIM must be divisible by BEAT_PIX (default 400/8 = 50 beats).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- z  input  1  synchronous clear; highest priority after reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  buffer accepts a beat this cycle.
- in_data  input  8*BEAT_PIX  beat; byte j (bits 8j+7:8j) = pixel j of the beat.
- full  output  1  complete tile held; reads are valid.
- rel  input  1  consumer releases the tile (pulse).
- rd  input  [4:0]  per-lane read strobe.
- row  input  [4:0][4:0]  per-lane row address.
- col  input  [4:0][4:0]  per-lane column address.
- q  output  [4:0][7:0]  per-lane registered read data.

## Operation
- Storage is DIM x DIM bytes.
- Beat counter `cnt` has width clog2(DIM*DIM/BEAT_PIX) and counts beats accepted in the current tile.
- Beat k, byte j is linear pixel p = k*BEAT_PIX + j, stored at row p/DIM, col p%DIM. Beats therefore cross row boundaries; with defaults, beat 2 fills row 0 cols 16-19 and row 1 cols 0-3.
- The state machine has two states, LOAD and FULL. Reset state is LOAD.
- LOAD:
  - in_ready=1, full=0.
  - A beat is accepted when in_valid and in_ready are both high at a rising edge. On acceptance, the beat is written and cnt increments.
  - Acceptance of the last beat (cnt = DIM*DIM/BEAT_PIX-1) moves the state to FULL and sets cnt to 0.
- FULL:
  - in_ready=0, full=1. in_valid is ignored and no writes occur.
  - rel=1 moves the state to LOAD. Storage is not cleared; the next load overwrites it.
- rel is ignored in LOAD.
- Reads, per lane i, evaluated independently at every edge:
  - If rd[i] and full: q[i] <= data[row[i]][col[i]]. If row[i]>=DIM or col[i]>=DIM, q[i] <= 0.
  - If rd[i] and not full: q[i] <= 0.
  - If rd[i]=0: q[i] holds its value.
- Any number of lanes may read any locations in the same cycle, including the same location. There is no contention.
- rd and rel in the same cycle: the read returns the current tile data; the state is LOAD afterwards.
- z=1 at an edge sets: state LOAD, cnt 0, all q 0, all storage 0. z overrides the handshake, reads and rel, so a beat presented with z is not accepted.
- rst_n low mid-load or mid-read aborts the operation and resets all state to the reset values below. The partial tile is discarded.
- Reset values: state LOAD, cnt 0, in_ready 1, full 0, q[0..4] 0, storage 0.

## Timing
- in_ready and full are decoded directly from the state register. There is no combinational path from in_valid, rel or rd to any output.
- Load throughput is one beat per cycle with no bubbles. A full tile takes DIM*DIM/BEAT_PIX consecutive accepted beats (50 with defaults).
- If the last beat is accepted at edge N, full=1 and in_ready=0 from edge N onward. A read issued in the cycle after edge N is captured at edge N+1 and returns tile data.
- Read latency is 1 cycle: rd/row/col sampled at edge M, q valid after edge M until the next read on that lane.
- rel sampled at edge M gives in_ready=1 after edge M. The next beat can be accepted at edge M+1.
- in_valid may be held high while in_ready=0; the beat stays pending until accepted.
- in_data is sampled only at accepting edges.

## Test plan
- Reset then stream 50 beats, with beat k byte j = (8k+j) mod 256 and in_valid held high -> full rises after the 50th acceptance, in_ready falls. Lane 0 reading (0,0) returns 0x00, (1,3) returns 0x17, (19,19) returns 0x8F (399 mod 256).
- Tile full; all 5 lanes read (19,19), (0,19), (20,0), (5,25), (10,10) in the same cycle -> q = 0x8F, 0x13, 0x00, 0x00, 0xD2 (210) one cycle later. Lanes with rd=0 in the following cycle hold their q.
- Insert random in_valid gaps during the load -> the stored tile matches the gap-free case. While FULL, an extra beat with in_valid=1 is not accepted and storage is unchanged.
- rel and a lane-2 read of (0,5) in the same cycle -> q[2]=0x05, in_ready=1 next cycle. A second tile of all 0xAA loads and reads back 0xAA everywhere. rel issued during LOAD has no effect on cnt.
- Assert z after 25 beats -> cnt returns to 0, storage and q are 0. A full 50-beat load afterwards is required before full=1.
- Assert rst_n low asynchronously between edges mid-load and mid-read -> outputs take the reset values immediately and full stays 0 until a new complete tile is loaded.
